// File: rtl/gain_ramp_stage.sv
// gain_ramp_stage: two-stage audio gain pipeline (operand register -> clipped product).
// Gain changes are slewed toward the latched target, one bounded step per accepted sample.
// Build option: define GAIN_RAMP_EN for the linear gain ramp; without it a gain_load
// takes effect in full at the next clock edge and ramping stays low.

module fixed_multiply #(
    parameter int fractional_size = 12,
    parameter int operand_size    = 32
) (
    input  logic signed [operand_size-1:0] a,
    input  logic signed [operand_size-1:0] b,
    output logic signed [operand_size-1:0] result
);
    logic signed [2*operand_size-1:0] w_full;
    logic                             w_unused_bits;

    // Full-precision product; the result keeps the operand_size bits above the fraction.
    assign w_full        = a * b;
    assign result        = w_full[fractional_size +: operand_size];
    assign w_unused_bits = ^{w_full[2*operand_size-1:fractional_size+operand_size],
                             w_full[fractional_size-1:0]};
endmodule

module gain_ramp_stage #(
    parameter int                       fractional_size = 12,
    parameter int                       operand_size    = 32,
    parameter logic [operand_size-1:0]  GAIN_MAX        = 32'h0000_8000,
    parameter int                       RAMP_STEP       = 4,
    parameter logic [operand_size-1:0]  CLIP_LEVEL      = 32'h0000_1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [operand_size-1:0] gain_target,
    input  logic                    gain_load,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [operand_size-1:0] in_sample,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [operand_size-1:0] out_sample,
    output logic [operand_size-1:0] gain_current,
    output logic                    ramping
);
    localparam logic signed [operand_size-1:0] LP_ONE      = operand_size'(1) << fractional_size;
    localparam logic signed [operand_size-1:0] LP_GAIN_MAX = GAIN_MAX;
    localparam logic signed [operand_size-1:0] LP_CLIP_POS = CLIP_LEVEL;
    localparam logic signed [operand_size-1:0] LP_CLIP_NEG = -CLIP_LEVEL;

    logic                           r_s1_valid;
    logic signed [operand_size-1:0] r_s1_sample;
    logic signed [operand_size-1:0] r_s1_gain;
    logic                           r_s2_valid;
    logic [operand_size-1:0]        r_s2_sample;
    logic signed [operand_size-1:0] r_gain;

    logic                           w_s2_adv;
    logic                           w_accept;
    logic signed [operand_size-1:0] w_product;
    logic signed [operand_size-1:0] w_clipped;
    logic signed [operand_size-1:0] w_target_clamped;

    assign w_s2_adv     = !r_s2_valid || out_ready;
    assign in_ready     = !r_s1_valid || w_s2_adv;
    assign w_accept     = in_valid && in_ready;
    assign out_valid    = r_s2_valid;
    assign out_sample   = r_s2_sample;
    assign gain_current = r_gain;

    fixed_multiply #(
        .fractional_size (fractional_size),
        .operand_size    (operand_size)
    ) u_mult (
        .a      (r_s1_sample),
        .b      (r_s1_gain),
        .result (w_product)
    );

    // Hard clip of the product to +/-CLIP_LEVEL, signed compare.
    always_comb begin
        w_clipped = w_product;
        if (w_product > LP_CLIP_POS) begin
            w_clipped = LP_CLIP_POS;
        end else if (w_product < LP_CLIP_NEG) begin
            w_clipped = LP_CLIP_NEG;
        end
    end

    // Requested gain clamped into [0, GAIN_MAX].
    always_comb begin
        w_target_clamped = $signed(gain_target);
        if ($signed(gain_target) < 0) begin
            w_target_clamped = '0;
        end else if ($signed(gain_target) > LP_GAIN_MAX) begin
            w_target_clamped = LP_GAIN_MAX;
        end
    end

    // S1: capture the sample with the gain in force before this accept's update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_sample <= '0;
            r_s1_gain   <= '0;
        end else if (w_accept) begin
            r_s1_valid  <= 1'b1;
            r_s1_sample <= $signed(in_sample);
            r_s1_gain   <= r_gain;
        end else if (w_s2_adv) begin
            r_s1_valid  <= 1'b0;
        end
    end

    // S2: register the clipped product; the data holds whenever S2 is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid  <= 1'b0;
            r_s2_sample <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_sample <= w_clipped;
            end
        end
    end

`ifdef GAIN_RAMP_EN
    localparam logic signed [operand_size-1:0] LP_STEP     = operand_size'(RAMP_STEP);
    localparam logic signed [operand_size-1:0] LP_STEP_NEG = -operand_size'(RAMP_STEP);

    logic signed [operand_size-1:0] r_target;
    logic signed [operand_size-1:0] w_delta;
    logic signed [operand_size-1:0] w_gain_next;

    // One bounded step toward the target; snaps onto it once within a step.
    always_comb begin
        w_delta     = r_target - r_gain;
        w_gain_next = r_target;
        if (w_delta > LP_STEP) begin
            w_gain_next = r_gain + LP_STEP;
        end else if (w_delta < LP_STEP_NEG) begin
            w_gain_next = r_gain - LP_STEP;
        end
    end

    // Gain moves only on accepts; a same-cycle load retargets from the next cycle on.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gain   <= LP_ONE;
            r_target <= LP_ONE;
        end else begin
            if (w_accept) begin
                r_gain <= w_gain_next;
            end
            if (gain_load) begin
                r_target <= w_target_clamped;
            end
        end
    end

    assign ramping = (r_gain != r_target);
`else
    logic w_unused_step;

    // Gain jumps straight to the clamped target; a same-cycle accept already took the old gain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gain <= LP_ONE;
        end else if (gain_load) begin
            r_gain <= w_target_clamped;
        end
    end

    assign ramping       = 1'b0;
    assign w_unused_step = (RAMP_STEP != 0);
`endif

endmodule

// File: tb/tb_gain_ramp_stage.sv
// Randomised and directed bench for gain_ramp_stage against a transaction-level model:
// a queue of expected outputs (value and accept cycle) plus the modelled gain/target.
module tb_gain_ramp_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] gain_target;
    logic        gain_load;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_sample;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sample;
    logic [31:0] gain_current;
    logic        ramping;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int m_gain;
    int m_target;
    logic [31:0] exp_val[$];
    int          exp_acc[$];
    logic [31:0] last_out;

    always #5 clk = ~clk;

    gain_ramp_stage dut (
        .clk          (clk),
        .rst          (rst),
        .gain_target  (gain_target),
        .gain_load    (gain_load),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sample    (in_sample),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sample   (out_sample),
        .gain_current (gain_current),
        .ramping      (ramping)
    );

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Product in Q.12 with floor rounding (>>> on a signed 64-bit value), then hard clip to +/-1.0.
    function automatic logic [31:0] mdl_out(input logic [31:0] s, input int g);
        longint p;
        p = longint'($signed(s)) * longint'(g);
        p = p >>> 12;
        if (p > 4096) p = 4096;
        else if (p < -4096) p = -4096;
        return p[31:0];
    endfunction

    function automatic int clamp_target(input logic [31:0] t);
        int v;
        v = $signed(t);
        if (v < 0) return 0;
        if (v > 32'h8000) return 32'h8000;
        return v;
    endfunction

    function automatic logic exp_ramping();
`ifdef GAIN_RAMP_EN
        return m_gain != m_target;
`else
        return 1'b0;
`endif
    endfunction

    // One clock: inputs already driven after a negedge; compare, advance model, cross the edge.
    task automatic step();
        bit exp_ready, exp_valid, acc, emit;
        int d;
        #1;
        if (!rst) begin
            exp_ready = (exp_val.size() < 2) || out_ready;
            exp_valid = (exp_val.size() > 0) && (cyc >= exp_acc[0] + 2);
            check1("in_ready", in_ready, exp_ready);
            check1("out_valid", out_valid, exp_valid);
            if (exp_valid) check32("out_sample", out_sample, exp_val[0]);
            check32("gain_current", gain_current, m_gain);
            check1("ramping", ramping, exp_ramping());
            acc  = in_valid && exp_ready;
            emit = exp_valid && out_ready;
            if (emit) begin
                last_out = out_sample;
                void'(exp_val.pop_front());
                void'(exp_acc.pop_front());
            end
            if (acc) begin
                exp_val.push_back(mdl_out(in_sample, m_gain));
                exp_acc.push_back(cyc);
`ifdef GAIN_RAMP_EN
                d = m_target - m_gain;
                if (d <= 4 && d >= -4) m_gain = m_target;
                else m_gain = m_gain + ((d > 0) ? 4 : -4);
`endif
            end
            if (gain_load) begin
                m_target = clamp_target(gain_target);
`ifndef GAIN_RAMP_EN
                m_gain = m_target;
`endif
            end
        end
        @(posedge clk);
        if (rst) begin
            exp_val.delete();
            exp_acc.delete();
            m_gain   = 32'h1000;
            m_target = 32'h1000;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] s);
        in_valid  = 1'b1;
        in_sample = s;
        step();
        in_valid  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load(input logic [31:0] t);
        gain_load   = 1'b1;
        gain_target = t;
        step();
        gain_load   = 1'b0;
    endtask

    initial begin
        logic [31:0] ramp_exp[5];
        rst = 1'b1; gain_target = '0; gain_load = 1'b0;
        in_valid = 1'b0; in_sample = '0; out_ready = 1'b1;
        m_gain = 32'h1000; m_target = 32'h1000; last_out = '0;
        @(negedge clk);
        step(); step();
        rst = 1'b0;
        #1;
        check32("rst_gain", gain_current, 32'h1000);
        check1("rst_out_valid", out_valid, 1'b0);
        check1("rst_in_ready", in_ready, 1'b1);
        check32("rst_out_sample", out_sample, 32'h0);
        check1("rst_ramping", ramping, 1'b0);
        @(negedge clk);

        send(32'h800); idle(3);
        check32("unity_half", last_out, 32'h800);
        send(32'h1800); idle(3);
        check32("clip_pos", last_out, 32'h1000);
        send(32'hFFFF_E800); idle(3);
        check32("clip_neg", last_out, 32'hFFFF_F000);

`ifdef GAIN_RAMP_EN
        load(32'h1010);
        ramp_exp = '{32'h1004, 32'h1008, 32'h100C, 32'h1010, 32'h1010};
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_sample = 32'h100 * (i + 1);
            step();
            check32("ramp_gain", gain_current, ramp_exp[i]);
            check1("ramp_flag", ramping, (i < 3) ? 1'b1 : 1'b0);
        end
        in_valid = 1'b0;
        idle(3);
        check32("ramp_last_out", last_out, 32'h0000_0505);
        load(32'hFFFF_0000); idle(1);
        check1("ramp_retarget_zero", ramping, 1'b1);
`else
        load(32'h2000);
        send(32'h800); idle(3);
        check32("gain2_clip", last_out, 32'h1000);
        send(32'hFFFF_F800); idle(3);
        check32("gain2_clip_neg", last_out, 32'hFFFF_F000);
        load(32'hFFFF_0000);
        check32("clamp_low", gain_current, 32'h0);
        load(32'h0010_0000);
        check32("clamp_high", gain_current, 32'h8000);
        load(32'h1000);
`endif

        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_sample = 32'($urandom_range(0, 32'h4000)) - 32'h2000;
            out_ready = ($urandom_range(0, 9) < 6);
            gain_load = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0: gain_target = 32'($urandom_range(0, 32'h9000));
                1: gain_target = 32'h1000 + 32'($urandom_range(0, 64)) - 32'd32;
                2: gain_target = 32'hFFFF_0000 + 32'($urandom_range(0, 255));
                default: gain_target = 32'h0010_0000;
            endcase
            step();
        end
        gain_load = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1;
        idle(4);

        out_ready = 1'b0; in_valid = 1'b1; in_sample = 32'h400;
        idle(3);
        #1;
        check1("full_stall_ready", in_ready, 1'b0);
        check1("full_stall_valid", out_valid, 1'b1);
        @(negedge clk);
        rst = 1'b1; step(); rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        check1("rst_mid_valid", out_valid, 1'b0);
        check1("rst_mid_ready", in_ready, 1'b1);
        check32("rst_mid_gain", gain_current, 32'h1000);
        @(negedge clk);
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
